// File: rtl/uc_secuencial.sv
// -----------------------------------------------------------------------------
// uc_secuencial
//
// Multicycle sequencing control unit for the microc datapath. Each instruction
// takes two cycles: FETCH captures the opcode into an instruction register,
// and EXEC decodes that register into the datapath control word. Illegal
// opcodes park the unit in HALT until reset. A saturating counter records the
// number of retired (legal) instructions.
//
// Parameters
//   COUNT_W      width of the retired-instruction counter (default 16)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   Opcode[5:0]  opcode from instruction memory, sampled on the FETCH->EXEC edge
//   z            zero flag from the datapath flag register (used live in EXEC)
//   run          1 = free-running, 0 = hold in FETCH
//   s_inc        PC mux select: 1 = PC+1, 0 = jump target
//   s_inm        register-file write-data select: 1 = immediate, 0 = ALU
//   we3          register-file write enable
//   wez          zero-flag register write enable
//   Op[2:0]      ALU operation code
//   pc_we        PC load enable
//   halted       1 while parked in HALT
//   instr_count  saturating retired-instruction count
// -----------------------------------------------------------------------------
module uc_secuencial #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    input  logic               z,
    input  logic               run,
    output logic               s_inc,
    output logic               s_inm,
    output logic               we3,
    output logic               wez,
    output logic [2:0]         Op,
    output logic               pc_we,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Decoded control word, independent of which state we are in.
    typedef struct packed {
        logic       legal;
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
    } ctrl_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [5:0]         r_ir;
    logic [COUNT_W-1:0] r_instr_count;

    ctrl_t              w_dec;
    logic               w_in_exec;
    logic               w_retire;
    logic               w_count_full;

    // -------------------------------------------------------------------------
    // Opcode decode from the instruction register. The live z is folded in
    // here so conditional jumps see the flag written by the previous
    // instruction.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // that no path leaves it unassigned and no latch is inferred.
        w_dec = '0;
        casez (r_ir)
            6'b1?????: begin // ALU operation
                w_dec.legal = 1'b1;
                w_dec.op    = r_ir[4:2];
                w_dec.we3   = 1'b1;
                w_dec.wez   = 1'b1;
                w_dec.s_inc = 1'b1;
            end
            6'b000000: begin // nop
                w_dec.legal = 1'b1;
                w_dec.s_inc = 1'b1;
            end
            6'b0001??: begin // li
                w_dec.legal = 1'b1;
                w_dec.s_inm = 1'b1;
                w_dec.we3   = 1'b1;
                w_dec.s_inc = 1'b1;
            end
            6'b010000: begin // j
                w_dec.legal = 1'b1;
                w_dec.s_inc = 1'b0;
            end
            6'b010001: begin // jz: take the jump when z is set
                w_dec.legal = 1'b1;
                w_dec.s_inc = ~z;
            end
            6'b010010: begin // jnz: take the jump when z is clear
                w_dec.legal = 1'b1;
                w_dec.s_inc = z;
            end
            default: begin
                w_dec = '0; // illegal: nothing is written, PC included
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RST:   w_state_next = ST_FETCH;
            ST_FETCH: if (run) w_state_next = ST_EXEC;
            ST_EXEC:  w_state_next = w_dec.legal ? ST_FETCH : ST_HALT;
            ST_HALT:  w_state_next = ST_HALT;
            default:  w_state_next = ST_RST;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs. Control is driven only in EXEC; because it is decoded from the
    // state register, an asynchronous reset mid-EXEC drops it immediately and
    // no datapath write lands on the following edge.
    // -------------------------------------------------------------------------
    assign w_in_exec    = (r_state == ST_EXEC);
    assign w_retire     = w_in_exec && w_dec.legal;
    assign w_count_full = &r_instr_count;

    always_comb begin
        s_inc  = 1'b0;
        s_inm  = 1'b0;
        we3    = 1'b0;
        wez    = 1'b0;
        Op     = 3'b000;
        pc_we  = 1'b0;
        if (w_in_exec) begin
            s_inc = w_dec.s_inc;
            s_inm = w_dec.s_inm;
            we3   = w_dec.we3;
            wez   = w_dec.wez;
            Op    = w_dec.op;
            pc_we = w_dec.legal;
        end
    end

    assign halted      = (r_state == ST_HALT);
    assign instr_count = r_instr_count;

    // -------------------------------------------------------------------------
    // State, instruction register and retired-instruction counter.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, regardless of block ordering.
        if (reset) begin
            r_state       <= ST_RST;
            r_ir          <= 6'b000000;
            r_instr_count <= '0;
        end else begin
            r_state <= w_state_next;

            // Opcode is only meaningful on the edge that leaves FETCH.
            if (r_state == ST_FETCH && run) begin
                r_ir <= Opcode;
            end

            // Saturate rather than wrap.
            if (w_retire && !w_count_full) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/uc_secuencial.md
# uc_secuencial

Multicycle sequencing control unit for the `microc` simple CPU datapath. It latches the 6-bit `Opcode` presented by the datapath and decodes it into the datapath control word `s_inc`, `s_inm`, `we3`, `wez`, `Op`, plus a PC-load enable. It steps through a fetch/execute state machine, supports run/stop single-stepping, and halts on illegal opcodes. It counts retired instructions and replaces the hand-driven control stimulus that currently sits in front of `microc`.

## Interface
- `COUNT_W`, default 16: width of the retired-instruction counter.

- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `Opcode`  input  6  instruction opcode from the datapath/instruction memory; valid during FETCH.
- `z`  input  1  zero flag from the datapath flag register.
- `run`  input  1  1 = free-running; 0 = hold in FETCH (stop/step control).
- `s_inc`  output  1  PC mux select: 1 = PC+1, 0 = jump target.
- `s_inm`  output  1  register-file write-data select: 1 = immediate, 0 = ALU result.
- `we3`  output  1  register-file write enable.
- `wez`  output  1  zero-flag register write enable.
- `Op`  output  3  ALU operation code.
- `pc_we`  output  1  PC register load enable.
- `halted`  output  1  1 while in HALT.
- `instr_count`  output  COUNT_W  retired-instruction count, saturating.

## Operation
- State machine states: RST, FETCH, EXEC, HALT.
  - RST goes to FETCH unconditionally.
  - FETCH goes to EXEC when `run`=1 and holds otherwise.
  - EXEC goes to FETCH for a legal opcode and to HALT for an illegal one.
  - HALT is left only by `reset`.
- FETCH: all control outputs are 0 and `pc_we`=0. On the edge that leaves FETCH, `Opcode` is captured into an internal instruction register `ir`.
- EXEC: outputs are decoded combinationally from `ir` and the live `z`. Every legal opcode asserts `pc_we`=1.
- Decode, for the EXEC cycle; unlisted outputs are 0:
  - `1?????` ALU operation: `Op`=`ir[4:2]`, `we3`=1, `wez`=1, `s_inc`=1.
  - `000000` nop: `s_inc`=1.
  - `0001??` li: `s_inm`=1, `we3`=1, `s_inc`=1.
  - `010000` j: `s_inc`=0.
  - `010001` jz: `s_inc`=~`z`.
  - `010010` jnz: `s_inc`=`z`.
  - Any other opcode is illegal: all outputs 0, including `pc_we`. The PC, registers and flag are untouched.
- HALT: all control outputs 0, `pc_we`=0, `halted`=1.
- `instr_count`:
  - Increments by 1 on the edge leaving EXEC with a legal opcode.
  - Saturates at 2^COUNT_W−1; never wraps.
  - Does not increment for an illegal opcode.
- `run` is sampled only in FETCH. Dropping `run` during EXEC still completes that instruction.

## Timing
- Asynchronous `reset` gives state=RST, `ir`=0, `instr_count`=0, and all outputs 0, including `halted`.
- The first FETCH is 1 cycle after `reset` deasserts, because RST lasts exactly 1 cycle.
- Each instruction takes 2 cycles (FETCH + EXEC) with `run`=1 continuously. With COUNT_W=16, the peak retire rate is 1 per 2 cycles.
- Control outputs are valid for the entire EXEC cycle. The datapath commits PC, register and flag writes on the edge ending EXEC.
- `z` must reflect the previous instruction's flag write, which is stable at EXEC because the flag register updates on the EXEC→FETCH edge.
- `Opcode` may change freely outside FETCH. Only its value at the FETCH→EXEC edge is used.
- Reset asserted mid-EXEC immediately drops all outputs, so no write is committed on the next edge. Reset asserted in HALT gives RST.

## Test plan
- Reset, then `run`=1 with `Opcode`=`100100` → the EXEC cycle shows `Op`=001, `we3`=1, `wez`=1, `s_inc`=1, `pc_we`=1; `instr_count`=1 after 2 cycles.
- Sequence li (`000100`), nop, j (`010000`) → the EXEC cycles show (`s_inm`,`we3`,`s_inc`)=(1,1,1), then (0,0,1), then (0,0,0) with `pc_we`=1; `instr_count`=3 after 6 cycles.
- jz with `z`=1 gives `s_inc`=0, and with `z`=0 gives `s_inc`=1; jnz gives the inverse in both cases; `wez`=0 in all four cases.
- `run`=0 for 5 cycles in FETCH → outputs stay 0 and `instr_count` is unchanged. Raising `run` → the next cycle is EXEC.
- Illegal `Opcode`=`011111` → the EXEC cycle has all outputs 0, then `halted`=1 permanently with `instr_count` unchanged. Async reset → `halted`=0 and the FSM is in RST.
- With COUNT_W=2, 5 legal instructions → `instr_count` sticks at 3. A reset pulse mid-EXEC of an ALU op → `we3` drops to 0 combinationally before the next edge.
